// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - commit-trace capture FIFO with timestamped records and drop accounting
module trace_capture #(
    parameter int DEPTH   = 16,
    parameter int STAMP_W = 16,
    parameter int DATA_W  = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              en,
    input  logic                              reg_write_sig,
    input  logic [4:0]                        reg_num,
    input  logic [DATA_W-1:0]                 reg_data,
    input  logic                              wr,
    input  logic                              rd,
    input  logic [8:0]                        addr,
    input  logic [DATA_W-1:0]                 wr_data,
    input  logic [DATA_W-1:0]                 rd_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [STAMP_W+2*DATA_W+18-1:0]    out_rec,
    output logic [$clog2(DEPTH):0]            level,
    output logic                              overflow,
    output logic [15:0]                       drop_count
);

    localparam int REC_W = STAMP_W + 2*DATA_W + 18;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [REC_W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_level;
    logic [REC_W-1:0]   r_head;
    logic               r_overflow;
    logic [15:0]        r_drop_count;
    logic [STAMP_W-1:0] r_stamp;
    logic               r_lost_pend;

    logic               w_rw;
    logic               w_mem;
    logic               w_event;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [AW:0]        w_level_next;
    logic [AW-1:0]      w_rd_ptr_next;
    logic [REC_W-1:0]   w_rec;

    // Writes to x0 are architecturally invisible, so they never form an event.
    assign w_rw    = reg_write_sig & (reg_num != 5'd0);
    assign w_mem   = wr | rd;
    assign w_event = en & (w_rw | w_mem);

    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign w_pop   = (r_level != '0) & out_ready;
    assign w_push  = w_event & ((r_level != LVL_FULL) | w_pop);
    assign w_drop  = w_event & ~w_push;

    assign w_level_next  = r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign w_rd_ptr_next = r_rd_ptr + AW'(w_pop);

    // Unused fields are zeroed so records compare cleanly; write data wins when both strobes fire.
    assign w_rec = {
        r_lost_pend,
        r_stamp,
        w_rw,
        w_rw  ? reg_num  : 5'd0,
        w_rw  ? reg_data : {DATA_W{1'b0}},
        wr,
        rd,
        w_mem ? addr : 9'd0,
        w_mem ? (wr ? wr_data : rd_data) : {DATA_W{1'b0}}
    };

    assign out_valid  = (r_level != '0);
    assign out_rec    = r_head;
    assign level      = r_level;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

    // Record storage; stale entries are harmless because the pointers are reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_rec;
        end
    end

    // Pointers, occupancy and the registered show-ahead head record.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_ptr_next;
            r_level  <= w_level_next;
            if (w_level_next != '0) begin
                // A single surviving entry that is being written now must bypass the array.
                if (w_push && (w_level_next == (AW+1)'(1))) begin
                    r_head <= w_rec;
                end else begin
                    r_head <= r_mem[w_rd_ptr_next];
                end
            end
        end
    end

    // Free-running stamp, independent of capture enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stamp <= '0;
        end else begin
            r_stamp <= r_stamp + STAMP_W'(1);
        end
    end

    // Drop accounting: sticky overflow, saturating count, and a lost marker for the next record.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
            r_lost_pend  <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow  <= 1'b1;
                r_lost_pend <= 1'b1;
                if (r_drop_count != 16'hFFFF) begin
                    r_drop_count <= r_drop_count + 16'd1;
                end
            end else if (w_push) begin
                r_lost_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trace_capture.sv
// tb/tb_trace_capture.sv - scoreboard bench for trace_capture
module tb_trace_capture;

    localparam int DEPTH   = 16;
    localparam int STAMP_W = 16;
    localparam int DATA_W  = 32;
    localparam int REC_W   = STAMP_W + 2*DATA_W + 18;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic              reg_write_sig;
    logic [4:0]        reg_num;
    logic [DATA_W-1:0] reg_data;
    logic              wr;
    logic              rd;
    logic [8:0]        addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [REC_W-1:0]  out_rec;
    logic [4:0]        level;
    logic              overflow;
    logic [15:0]       drop_count;

    trace_capture #(.DEPTH(DEPTH), .STAMP_W(STAMP_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .en(en),
        .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
        .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_rec(out_rec),
        .level(level), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int               checks   = 0;
    int               failures = 0;
    logic [REC_W-1:0] sb[$];
    logic [REC_W-1:0] m_last;
    logic [15:0]      m_stamp;
    int               m_drops;
    logic             m_ovf;
    logic             m_lost;
    logic             saw_wrap;
    logic             have_prev;
    logic [15:0]      prev_stamp;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [REC_W-1:0] model_rec(input logic lost, input logic [15:0] st);
        logic rw;
        logic mem;
        rw  = reg_write_sig && (reg_num != 5'd0);
        mem = wr || rd;
        return {lost, st, rw,
                rw  ? reg_num  : 5'd0,
                rw  ? reg_data : 32'd0,
                wr, rd,
                mem ? addr : 9'd0,
                mem ? (wr ? wr_data : rd_data) : 32'd0};
    endfunction

    task automatic model_clear();
        sb.delete();
        m_last    = '0;
        m_stamp   = '0;
        m_drops   = 0;
        m_ovf     = 1'b0;
        m_lost    = 1'b0;
        have_prev = 1'b0;
    endtask

    task automatic idle_inputs();
        reg_write_sig = 1'b0;
        reg_num       = 5'd0;
        reg_data      = '0;
        wr            = 1'b0;
        rd            = 1'b0;
        addr          = '0;
        wr_data       = '0;
        rd_data       = '0;
    endtask

    task automatic rand_event();
        reg_write_sig = 1'($urandom_range(0, 1));
        reg_num       = 5'($urandom_range(1, 31));
        reg_data      = $urandom();
        wr            = 1'($urandom_range(0, 1));
        rd            = 1'($urandom_range(0, 1));
        addr          = 9'($urandom_range(0, 511));
        wr_data       = $urandom();
        rd_data       = $urandom();
        if (!reg_write_sig && !wr && !rd) wr = 1'b1;
    endtask

    // One clock: score the head before the edge, update the model, then check state at negedge.
    task automatic cycle();
        logic        ev;
        logic        pop;
        logic        acc;
        logic [15:0] st;
        ev  = en && ((reg_write_sig && reg_num != 5'd0) || wr || rd);
        pop = (sb.size() > 0) && out_ready;
        acc = ev && ((sb.size() < DEPTH) || pop);
        if (pop) begin
            check("head_rec", out_rec, sb[0]);
            st = sb[0][96:81];
            if (have_prev && prev_stamp == 16'hFFFF && st == 16'h0000) saw_wrap = 1'b1;
            prev_stamp = st;
            have_prev  = 1'b1;
            m_last = sb.pop_front();
        end
        if (acc) begin
            sb.push_back(model_rec(m_lost, m_stamp));
            m_lost = 1'b0;
        end else if (ev) begin
            m_drops++;
            m_ovf  = 1'b1;
            m_lost = 1'b1;
        end
        @(posedge clk);
        m_stamp = m_stamp + 16'd1;
        @(negedge clk);
        check("level", level, sb.size());
        check("out_valid", out_valid, sb.size() != 0);
        check("overflow", overflow, m_ovf);
        check("drop_count", drop_count, (m_drops > 65535) ? 16'hFFFF : m_drops[15:0]);
        check("out_rec", out_rec, (sb.size() != 0) ? sb[0] : m_last);
    endtask

    initial begin
        saw_wrap = 1'b0;
        model_clear();
        reset     = 1'b0;
        en        = 1'b1;
        out_ready = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 1'b0);
        check("rst_level", level, 5'd0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_drop", drop_count, 16'd0);
        check("rst_rec", out_rec, '0);
        reset = 1'b1;

        // Register write captured at stamp 3.
        out_ready = 1'b1;
        while (m_stamp != 16'd3) cycle();
        reg_write_sig = 1'b1;
        reg_num       = 5'd5;
        reg_data      = 32'hDEADBEEF;
        cycle();
        check("t1_valid", out_valid, 1'b1);
        check("t1_lost", out_rec[97], 1'b0);
        check("t1_stamp", out_rec[96:81], 16'd3);
        check("t1_rw", out_rec[80], 1'b1);
        check("t1_regnum", out_rec[79:75], 5'd5);
        check("t1_regdata", out_rec[74:43], 32'hDEADBEEF);
        check("t1_memfields", out_rec[42:0], 43'd0);
        idle_inputs();
        cycle();
        check("t1_level_after_pop", level, 5'd0);

        // x0 write is ignored; dual memory strobe takes write data.
        reg_write_sig = 1'b1;
        reg_num       = 5'd0;
        reg_data      = 32'h1234;
        cycle();
        check("t2_x0_level", level, 5'd0);
        idle_inputs();
        wr = 1'b1; rd = 1'b1; addr = 9'h1F0; wr_data = 32'h11; rd_data = 32'h22;
        cycle();
        check("t2_rw", out_rec[80], 1'b0);
        check("t2_memwr", out_rec[42], 1'b1);
        check("t2_memrd", out_rec[41], 1'b1);
        check("t2_addr", out_rec[40:32], 9'h1F0);
        check("t2_data", out_rec[31:0], 32'h11);
        idle_inputs();
        cycle();

        // Overfill by three, then drain and see the lost marker on the next record.
        out_ready = 1'b0;
        repeat (DEPTH + 3) begin rand_event(); cycle(); end
        idle_inputs();
        check("t3_level", level, 5'd16);
        check("t3_overflow", overflow, 1'b1);
        check("t3_drop", drop_count, 16'd3);
        out_ready = 1'b1;
        repeat (DEPTH) cycle();
        check("t3_drained", level, 5'd0);
        rand_event();
        cycle();
        check("t3_lost", out_rec[97], 1'b1);
        idle_inputs();
        cycle();

        // Full FIFO with simultaneous push and pop holds level.
        out_ready = 1'b0;
        repeat (DEPTH) begin rand_event(); cycle(); end
        check("t4_full", level, 5'd16);
        out_ready = 1'b1;
        repeat (20) begin
            rand_event();
            cycle();
            check("t4_level_hold", level, 5'd16);
            check("t4_drop_hold", drop_count, 16'd3);
        end

        // Long drop run up to the stamp wrap, flow across it, then saturate the counter.
        out_ready = 1'b0;
        while (m_stamp != 16'hFFE0) begin rand_event(); cycle(); end
        out_ready = 1'b1;
        repeat (64) begin rand_event(); cycle(); end
        out_ready = 1'b0;
        repeat (5000) begin rand_event(); cycle(); end
        check("t5_drop_sat", drop_count, 16'hFFFF);
        check("t5_stamp_wrap_seen", saw_wrap, 1'b1);

        // Asynchronous reset in the middle of a drain.
        idle_inputs();
        out_ready = 1'b1;
        repeat (9) cycle();
        check("t6_level7", level, 5'd7);
        #2 reset = 1'b0;
        #1;
        check("t6_async_valid", out_valid, 1'b0);
        check("t6_async_level", level, 5'd0);
        check("t6_async_overflow", overflow, 1'b0);
        check("t6_async_drop", drop_count, 16'd0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Capture disabled: no records and no drops.
        en        = 1'b0;
        out_ready = 1'b0;
        repeat (20) begin rand_event(); cycle(); end
        check("t7_en0_level", level, 5'd0);
        check("t7_en0_drop", drop_count, 16'd0);
        en = 1'b1;
        repeat (DEPTH) begin rand_event(); cycle(); end
        en = 1'b0;
        repeat (5) begin rand_event(); cycle(); end
        check("t7_full_en0_drop", drop_count, 16'd0);
        check("t7_full_en0_level", level, 5'd16);
        check("t7_full_en0_ovf", overflow, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
- Commit-trace buffer downstream of the RISC-V core top; consumes the core's per-cycle register-writeback and data-memory observation outputs.
- Packs each cycle that carries an architectural event into one timestamped record and stores it in a show-ahead FIFO.
- Drains records over a valid/ready stream to a host link or bench scoreboard.
- Drops records on overflow and accounts for every dropped record, so the consumer can detect gaps in the trace.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2
STAMP_W, 16, width of the free-running cycle stamp
DATA_W, 32, register and memory data width

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
en  in  1  capture enable; 0 = no pushes (draining continues)
reg_write_sig  in  1  core register-file write strobe
reg_num  in  5  destination register
reg_data  in  DATA_W  data written to register file
wr  in  1  data-memory write strobe
rd  in  1  data-memory read strobe
addr  in  9  data-memory address
wr_data  in  DATA_W  memory write data
rd_data  in  DATA_W  memory read data
out_valid  out  1  head record available
out_ready  in  1  consumer accepts head record
out_rec  out  STAMP_W+2*DATA_W+18  head record, MSB to LSB: lost, stamp, rw, reg_num, reg_data, mem_wr, mem_rd, addr, mem_data
level  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky; set on first drop
drop_count  out  16  saturating count of dropped records

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0, out_rec=0, level=0, overflow=0, drop_count=0, stamp=0, pending-lost flag=0, FIFO pointers=0. All take effect immediately, including in the middle of a burst; records in flight are discarded.
- Stamp: increments by 1 every clock while reset=1, regardless of en. Wraps from 2^STAMP_W-1 to 0. A record carries the stamp value sampled in its capture cycle.
- Event qualification per cycle:
  - rw = reg_write_sig & (reg_num!=0); writes to x0 are ignored.
  - mem_wr = wr; mem_rd = rd.
  - event = en & (rw | mem_wr | mem_rd).
- Record fields:
  - When rw=0: reg_num and reg_data fields are 0.
  - When mem_wr=mem_rd=0: addr and mem_data fields are 0.
  - mem_data = wr_data if wr=1, else rd_data. When wr and rd are both 1, wr_data is used and both flags are recorded.
- Push: an event is written at the rising edge of its capture cycle. The record appears at the FIFO head (out_valid=1) in the following cycle if the FIFO was empty, giving 1-cycle latency.
- Pop: occurs when out_valid & out_ready at a rising edge; the next head appears in the next cycle. out_rec is stable while out_valid=1 and out_ready=0.
- Full: an event is accepted if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle (simultaneous push and pop; level is unchanged).
- Drop (event and not accepted):
  - record is discarded;
  - overflow set to 1, sticky until reset;
  - drop_count += 1, saturating at 16'hFFFF;
  - pending-lost flag set.
- Lost flag: the next accepted record has lost=1, and the pending-lost flag is cleared on that push.
- Empty: out_valid=0. out_rec holds its last value (0 after reset). A pop with out_valid=0 has no effect.
- Simultaneous push and pop when empty: the push is accepted; the pop is ignored (no valid head).
- Pointers wrap modulo DEPTH. level counts 0..DEPTH inclusive.
- en=0 blocks pushes only. Drops are not counted while en=0.

Test Plan:
- Reset, then reg_write_sig=1, reg_num=5, reg_data=32'hDEADBEEF at stamp 3, out_ready=1 -> next cycle out_valid=1; out_rec has rw=1, reg_num=5, reg_data=DEADBEEF, stamp=3, mem fields 0, lost=0; level returns to 0 after pop.
- Write to x0 with no memory strobe -> no record, level stays 0. Next cycle wr=1, rd=1, addr=9'h1F0, wr_data=32'h11, rd_data=32'h22 -> record has mem_wr=1, mem_rd=1, mem_data=32'h11.
- out_ready=0 with DEPTH+3 consecutive events -> level=16, overflow=1, drop_count=3. Raise out_ready -> 16 records in stamp order, all lost=0. Next accepted event has lost=1.
- FIFO full with out_ready=1 and an event every cycle -> level holds at 16, drop_count unchanged, records emerge in order.
- 70000 forced drops -> drop_count saturates at 16'hFFFF. Stamp wraps from FFFF to 0000 across recorded events.
- Assert reset=0 mid-drain with level=7 -> out_valid, level, overflow and drop_count go to 0 immediately, without waiting for a clock edge. With en=0, events produce no records and no drops.
